// File: rtl/tone_i2s_tx_pkg.sv
// Shared constants and types for the tone-word I2S transmitter.
// A tone word carries the left sample in its upper half and the right sample in its lower half.
package tone_i2s_tx_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int TONE_L_MSB = 31;
    localparam int TONE_R_MSB = 15;

    localparam int BIT_CNT_W = $clog2(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST     = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] RIGHT_SLOT_FIRST = BIT_CNT_W'(FRAME_BITS / 2);

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } i2s_slot_e;

    // LRCLK level for a given bit slot of the frame.
    function automatic i2s_slot_e slot_of(input logic [BIT_CNT_W-1:0] bit_cnt);
        return (bit_cnt >= RIGHT_SLOT_FIRST) ? SLOT_RIGHT : SLOT_LEFT;
    endfunction

endpackage

// File: rtl/tone_i2s_tx_if.sv
// Write-side bus between the processor's tone output port and the transmitter FIFO.
// The master drives ld_fifo/tone; the slave reports occupancy and overflow.
interface tone_i2s_tx_if #(
    parameter int DEPTH = 16
) ();

    logic                     ld_fifo;
    logic [31:0]              tone;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     overflow;

    modport master (
        output ld_fifo, tone,
        input  fifo_full, fifo_empty, fifo_count, overflow
    );

    modport slave (
        input  ld_fifo, tone,
        output fifo_full, fifo_empty, fifo_count, overflow
    );

endinterface

// File: rtl/tone_i2s_tx_fifo.sv
// Synchronous FIFO for tone words; full/empty are registered from the next occupancy.
// Full and empty gate push/pop using the pre-cycle state, so a write into a full FIFO is dropped even if a pop happens the same cycle.
module tone_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic [WIDTH-1:0] head,
    output logic             pop_ok,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;

    always_comb begin
        push       = push_req && !full_q;
        pop        = pop_req && !empty_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d     = (count_d == CNT_W'(DEPTH));
        empty_d    = (count_d == '0);
        overflow_d = push_req && full_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign pop_ok   = pop;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/tone_i2s_tx.sv
// Tone-word FIFO consumer that serialises one {left,right} word per frame as I2S.
// BCLK/LRCLK are divided from clk; data changes on BCLK falling edges with the standard one-bit delay.
module tone_i2s_tx
    import tone_i2s_tx_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BCLK_DIV = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    tone_i2s_tx_if.slave   wr,
    output logic           underrun,
    output logic           i2s_bclk,
    output logic           i2s_lrclk,
    output logic           i2s_dout
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  bclk_q, bclk_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  lrclk_q, lrclk_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  dout_q, dout_d;
    logic                  underrun_q, underrun_d;

    logic                  div_tick;
    logic                  bclk_fall;
    logic                  frame_start;
    logic                  pop_req;
    logic                  pop_ok;
    logic [FRAME_BITS-1:0] head;

    tone_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (wr.ld_fifo),
        .push_data (wr.tone),
        .pop_req   (pop_req),
        .head      (head),
        .pop_ok    (pop_ok),
        .full      (wr.fifo_full),
        .empty     (wr.fifo_empty),
        .count     (wr.fifo_count),
        .overflow  (wr.overflow)
    );

    always_comb begin
        div_tick    = (div_cnt_q == DIV_LAST);
        bclk_fall   = div_tick && bclk_q;
        frame_start = bclk_fall && (bit_cnt_q == BIT_CNT_LAST);
        pop_req     = frame_start && run;
    end

    always_comb begin
        div_cnt_d  = div_tick ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d     = div_tick ? ~bclk_q : bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrclk_d    = lrclk_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        underrun_d = 1'b0;

        // Everything in the serial path advances only on BCLK falling edges.
        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            lrclk_d   = slot_of(bit_cnt_d);
            dout_d    = shift_q[FRAME_BITS-1];
            if (frame_start) begin
                if (pop_ok) begin
                    shift_d = {head[TONE_L_MSB -: SAMPLE_W], head[TONE_R_MSB -: SAMPLE_W]};
                end else begin
                    shift_d    = '0;
                    underrun_d = pop_req;
                end
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q  <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= BIT_CNT_LAST;
            lrclk_q    <= SLOT_RIGHT;
            shift_q    <= '0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrclk_q    <= lrclk_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
        end
    end

    assign underrun  = underrun_q;
    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_dout  = dout_q;

endmodule

// File: tb/tb_tone_i2s_tx.sv
// Bench for tone_i2s_tx: directed scenarios plus random traffic, checked every cycle against a
// time-based reference model (frame position derived from cycles since reset, words held in a queue).
module tb_tone_i2s_tx;

    localparam int DEPTH    = 4;
    localparam int BCLK_DIV = 2;
    localparam int EDGE_P   = 2 * BCLK_DIV;
    localparam int FRAME_P  = 64 * BCLK_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic run   = 1'b0;
    logic underrun;
    logic i2s_bclk;
    logic i2s_lrclk;
    logic i2s_dout;

    tone_i2s_tx_if #(.DEPTH(DEPTH)) wr_if ();

    tone_i2s_tx #(
        .DEPTH    (DEPTH),
        .BCLK_DIV (BCLK_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .wr        (wr_if),
        .underrun  (underrun),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_dout  (i2s_dout)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;

    logic [31:0] model_q [$];
    int          model_t   = 0;
    logic [31:0] cur_word  = '0;
    logic [31:0] prev_word = '0;
    logic        exp_ovf   = 1'b0;
    logic        exp_und   = 1'b0;
    logic        run_r;
    int          rate;
    int          rate_table [4] = '{0, 1, 3, 12};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s at t=%0d: observed %0h expected %0h", tag, model_t, observed, expected);
        end
    endtask

    // Bit slot of the current frame as seen on the pins; 31 before the first falling edge.
    function automatic int slot_now();
        int k;
        k = model_t / EDGE_P;
        return (k == 0) ? 31 : (k - 1) % 32;
    endfunction

    // One clock cycle: drive inputs, advance the model across the edge, then compare everything.
    task automatic applyStimulus(input logic rst_in, input logic ld_in, input logic [31:0] tone_in, input logic run_in);
        int   pre_size;
        int   k;
        int   b;
        logic frame_start;
        logic exp_dout;
        logic exp_lrclk;
        reset         = rst_in;
        wr_if.ld_fifo = ld_in;
        wr_if.tone    = tone_in;
        run           = run_in;
        @(posedge clk);
        if (rst_in) begin
            model_q.delete();
            model_t   = 0;
            cur_word  = '0;
            prev_word = '0;
            exp_ovf   = 1'b0;
            exp_und   = 1'b0;
        end else begin
            pre_size    = model_q.size();
            model_t++;
            frame_start = (model_t % FRAME_P) == EDGE_P;
            exp_ovf     = ld_in && (pre_size == DEPTH);
            exp_und     = frame_start && run_in && (pre_size == 0);
            if (frame_start) begin
                prev_word = cur_word;
                cur_word  = (run_in && pre_size > 0) ? model_q.pop_front() : 32'h0;
            end
            if (ld_in && pre_size < DEPTH) model_q.push_back(tone_in);
        end
        @(negedge clk);
        k = model_t / EDGE_P;
        b = slot_now();
        if (k == 0)      exp_dout = 1'b0;
        else if (b == 0) exp_dout = prev_word[0];
        else             exp_dout = cur_word[32 - b];
        exp_lrclk = (b >= 16);
        checkOutput("fifo_count", 32'(wr_if.fifo_count), 32'(model_q.size()));
        checkOutput("fifo_full",  32'(wr_if.fifo_full),  32'(model_q.size() == DEPTH));
        checkOutput("fifo_empty", 32'(wr_if.fifo_empty), 32'(model_q.size() == 0));
        checkOutput("overflow",   32'(wr_if.overflow),   32'(exp_ovf));
        checkOutput("underrun",   32'(underrun),         32'(exp_und));
        checkOutput("bclk",       32'(i2s_bclk),         32'((model_t / BCLK_DIV) % 2));
        checkOutput("lrclk",      32'(i2s_lrclk),        32'(exp_lrclk));
        checkOutput("dout",       32'(i2s_dout),         32'(exp_dout));
    endtask

    initial begin
        wr_if.ld_fifo = 1'b0;
        wr_if.tone    = '0;
        @(negedge clk);

        $display("[TB] idle run with underruns");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] single known word");
        applyStimulus(1'b0, 1'b1, 32'hA5A5_0F0F, 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] fill past full, then hold writes across a frame start");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, $urandom(), 1'b0);
        for (int i = 0; i < 140; i++) applyStimulus(1'b0, 1'b1, $urandom(), 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] muted with two queued words, then unmute");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h8001_7FFE, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h1234_FEDC, 1'b0);
        for (int i = 0; i < 3 * FRAME_P; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3 * FRAME_P; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] random traffic");
        run_r = 1'b1;
        for (int blk = 0; blk < 8; blk++) begin
            rate = rate_table[blk % 4];
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 199) == 0) run_r = ~run_r;
                applyStimulus(1'b0, $urandom_range(0, 99) < rate, $urandom(), run_r);
            end
        end

        $display("[TB] reset in the middle of the right slot");
        for (int i = 0; i < 2 * FRAME_P && slot_now() != 20; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 9) == 0, $urandom(), 1'b1);
        end
        checkOutput("reach_right_slot", 32'(slot_now()), 32'd20);
        applyStimulus(1'b1, 1'b1, $urandom(), 1'b1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b0, $urandom_range(0, 19) == 0, $urandom(), 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
